core_debug_responder: RTL and testbench
=======================================

CORE_DEBUG_RESPONDER -- requirements
Module: core_debug_responder

Interface
REQ-001 P_TIMEOUT, default 255, SHALL be the maximum wait cycles for any core or register-file response before error; range 1..255.
REQ-002 iCLOCK  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 inRESET  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 iDEBUG_CMD_REQ  in  1  SHALL be the debugger command request.
REQ-005 oDEBUG_CMD_BUSY  out  1  SHALL indicate the responder cannot accept a command.
REQ-006 iDEBUG_CMD_COMMAND  in  4  SHALL be the command code: 0 READ_REG, 1 WRITE_REG, 8 GO, 9 INTGO, A SINGLESTEP, F STOP.
REQ-007 iDEBUG_CMD_TARGET  in  8  SHALL be the register target: GR0-31 = 0-31, system 64-78, previous-context 128-132.
REQ-008 iDEBUG_CMD_DATA  in  32  SHALL be the write data.
REQ-009 oDEBUG_CMD_VALID  out  1  SHALL be the one-cycle response pulse.
REQ-010 oDEBUG_CMD_ERROR  out  1  SHALL qualify VALID as a failed command.
REQ-011 oDEBUG_CMD_DATA  out  32  SHALL carry the response data.
REQ-012 oCORE_STOP_REQ  out  1  SHALL be the level request to halt the pipeline.
REQ-013 iCORE_STOPPED  in  1  SHALL be the core-halted status level.
REQ-014 oCORE_GO  out  1  SHALL be the resume pulse.
REQ-015 oCORE_GO_INT  out  1  SHALL be a flag valid with oCORE_GO that enables interrupts on resume.
REQ-016 oCORE_STEP  out  1  SHALL be the single-instruction pulse.
REQ-017 iCORE_STEP_DONE  in  1  SHALL be the single-step completion pulse.
REQ-018 oREG_REQ / oREG_RW / oREG_TARGET[8] / oREG_WDATA[32]  out  SHALL form the register-file access port (RW=1 write).
REQ-019 iREG_VALID  in  1 / iREG_RDATA  in  32  SHALL be the register-file completion and read data.

Function
REQ-020 States SHALL be IDLE, DECODE, STOP_WAIT, REG_WAIT, STEP_WAIT, RESP.
REQ-021 BUSY SHALL equal (state != IDLE); a command is accepted only on an edge with REQ=1 in IDLE, and COMMAND/TARGET/DATA are latched there; REQ while BUSY is ignored.
REQ-022 Accept SHALL move to DECODE; DECODE SHALL select the error path or a wait state in one cycle.
REQ-023 Error or immediate responses SHALL assert VALID in the second cycle after the accepting edge (DECODE, then RESP).
REQ-024 Error SHALL be flagged for: undefined command code; target outside 0-31/64-78/128-132; WRITE_REG to target 64 (CPUIDR); READ/WRITE/GO/INTGO/SINGLESTEP while iCORE_STOPPED=0.
REQ-025 STOP with iCORE_STOPPED=1 SHALL respond immediately without error; otherwise it enters STOP_WAIT, holding oCORE_STOP_REQ=1 until iCORE_STOPPED=1, then RESP.
REQ-026 GO/INTGO SHALL pulse oCORE_GO for exactly one cycle in DECODE, with oCORE_GO_INT=1 for INTGO only, then RESP without error.
REQ-027 SINGLESTEP SHALL pulse oCORE_STEP for one cycle in DECODE, then wait in STEP_WAIT for iCORE_STEP_DONE.
REQ-028 READ/WRITE SHALL hold oREG_REQ=1 with the latched RW, target and data throughout REG_WAIT until iREG_VALID=1; RDATA is captured on that edge.
REQ-029 An 8-bit wait counter SHALL clear on entry to every wait state; reaching P_TIMEOUT without completion SHALL respond with ERROR=1 and drop oCORE_STOP_REQ/oREG_REQ.
REQ-030 A completion arriving in the same cycle the counter hits P_TIMEOUT SHALL win (success).
REQ-031 oDEBUG_CMD_DATA SHALL be the read data for successful READ_REG and 0 otherwise; DATA and ERROR SHALL be 0 whenever VALID=0.
REQ-032 RESP SHALL last one cycle and return to IDLE; a new REQ is accepted no earlier than the following edge.

Reset
REQ-033 Reset SHALL force state=IDLE, counter=0, latches=0 and all outputs 0 (BUSY=0), including mid-operation; no VALID is produced for an aborted command.

Structure
REQ-034 Command codes, target numbers and state encodings SHALL live in a shared core-debug package/include used by both debugger and responder.
REQ-035 Target legality (range + write-protect) SHALL be a combinational sub-module core_debug_target_check.

Verification
REQ-036 Stopped core, READ_REG target 5, iREG_RDATA=0x1234_5678 after 3 cycles -> VALID=1, ERROR=0, DATA=0x12345678, BUSY high from accept to RESP.
REQ-037 Running core, STOP, iCORE_STOPPED rises 10 cycles later -> STOP_REQ high 10 cycles, VALID ERROR=0 DATA=0.
REQ-038 Stopped core, WRITE_REG target 64 and READ_REG target 40 -> each VALID+ERROR exactly 2 cycles after accept, oREG_REQ never asserted.
REQ-039 P_TIMEOUT=4, SINGLESTEP, no STEP_DONE -> one oCORE_STEP pulse, VALID+ERROR after 4 wait cycles; STEP_DONE on the 4th wait cycle -> ERROR=0.
REQ-040 INTGO while stopped -> single-cycle oCORE_GO with oCORE_GO_INT=1; GO while running -> ERROR=1, no oCORE_GO pulse.
REQ-041 inRESET asserted during REG_WAIT -> all outputs 0 immediately, no VALID after release, next READ_REG completes normally.

Source files
------------

// File: rtl/core_debug_pkg.sv
// -----------------------------------------------------------------------------
// core_debug_pkg
// Shared definitions for the core debug link, used by both the debugger side
// and the responder: command codes, register target map, responder FSM state
// encoding and small decode helpers.
// -----------------------------------------------------------------------------
package core_debug_pkg;

   // Debugger command codes
   localparam logic [3:0] CMD_READ_REG   = 4'h0;
   localparam logic [3:0] CMD_WRITE_REG  = 4'h1;
   localparam logic [3:0] CMD_GO         = 4'h8;
   localparam logic [3:0] CMD_INTGO      = 4'h9;
   localparam logic [3:0] CMD_SINGLESTEP = 4'hA;
   localparam logic [3:0] CMD_STOP       = 4'hF;

   // Register target map: GR0-31, system registers, previous-context registers
   localparam logic [7:0] TGT_GR_LAST    = 8'd31;
   localparam logic [7:0] TGT_SYS_FIRST  = 8'd64;
   localparam logic [7:0] TGT_SYS_LAST   = 8'd78;
   localparam logic [7:0] TGT_PREV_FIRST = 8'd128;
   localparam logic [7:0] TGT_PREV_LAST  = 8'd132;
   // CPU identification register is read-only
   localparam logic [7:0] TGT_CPUIDR     = 8'd64;

   // Responder FSM states
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_DECODE    = 3'd1,
      ST_STOP_WAIT = 3'd2,
      ST_REG_WAIT  = 3'd3,
      ST_STEP_WAIT = 3'd4,
      ST_RESP      = 3'd5
   } dbg_state_t;

   // True for any of the six defined command codes
   function automatic logic cmd_is_defined(input logic [3:0] cmd);
      logic r;
      case (cmd)
         CMD_READ_REG, CMD_WRITE_REG, CMD_GO,
         CMD_INTGO, CMD_SINGLESTEP, CMD_STOP: r = 1'b1;
         default:                             r = 1'b0;
      endcase
      return r;
   endfunction

   // Commands that touch the register file
   function automatic logic cmd_is_reg_access(input logic [3:0] cmd);
      return (cmd == CMD_READ_REG) || (cmd == CMD_WRITE_REG);
   endfunction

   // Every defined command except STOP requires the core to be halted
   function automatic logic cmd_needs_stopped(input logic [3:0] cmd);
      return cmd_is_defined(cmd) && (cmd != CMD_STOP);
   endfunction

   // True when the target number names an implemented register
   function automatic logic target_in_map(input logic [7:0] tgt);
      return (tgt <= TGT_GR_LAST) ||
             ((tgt >= TGT_SYS_FIRST)  && (tgt <= TGT_SYS_LAST)) ||
             ((tgt >= TGT_PREV_FIRST) && (tgt <= TGT_PREV_LAST));
   endfunction

endpackage

// File: rtl/core_debug_responder_target_check.sv
// -----------------------------------------------------------------------------
// core_debug_target_check
// Combinational legality check of a register target for a debug command.
// Non-register commands carry no meaningful target and are always legal.
//
// Ports
//   i_cmd     [3:0]  command code
//   i_target  [7:0]  register target number
//   o_legal          1 = target acceptable for this command
// -----------------------------------------------------------------------------
module core_debug_target_check
   import core_debug_pkg::*;
(
   input  logic [3:0] i_cmd,
   input  logic [7:0] i_target,
   output logic       o_legal
);

   logic w_is_reg;
   logic w_in_map;
   logic w_write_protected;

   always_comb begin
      w_is_reg          = cmd_is_reg_access(i_cmd);
      w_in_map          = target_in_map(i_target);
      w_write_protected = (i_cmd == CMD_WRITE_REG) && (i_target == TGT_CPUIDR);
      o_legal           = !w_is_reg || (w_in_map && !w_write_protected);
   end

endmodule

// File: rtl/core_debug_responder.sv
// -----------------------------------------------------------------------------
// core_debug_responder
// Executes debugger commands against the core: register reads/writes through
// the register-file port, halt, resume (with or without interrupts) and
// single-step. Every accepted command ends in exactly one VALID pulse.
//
// Command handshake: the responder samples iDEBUG_CMD_REQ on a rising edge only
// while oDEBUG_CMD_BUSY=0 (IDLE); that edge accepts and latches
// COMMAND/TARGET/DATA. BUSY stays high until the single-cycle
// oDEBUG_CMD_VALID pulse (with ERROR/DATA) has been presented; the debugger
// cannot stall the response. REQ seen while BUSY=1 is ignored.
//
// Ports
//   iCLOCK, inRESET              clock, asynchronous active-low reset
//   iDEBUG_CMD_*/oDEBUG_CMD_*    debugger command / response
//   oCORE_STOP_REQ, iCORE_STOPPED halt request level / core halted level
//   oCORE_GO, oCORE_GO_INT       resume pulse, interrupt-enable qualifier
//   oCORE_STEP, iCORE_STEP_DONE  single-step pulse / completion pulse
//   oREG_*/iREG_*                register-file access port (RW=1 write)
//   oDEBUG_STATE                 current FSM state, for observation
// -----------------------------------------------------------------------------
module core_debug_responder
   import core_debug_pkg::*;
#(
   parameter int unsigned P_TIMEOUT = 255
)(
   input  logic        iCLOCK,
   input  logic        inRESET,
   input  logic        iDEBUG_CMD_REQ,
   output logic        oDEBUG_CMD_BUSY,
   input  logic [3:0]  iDEBUG_CMD_COMMAND,
   input  logic [7:0]  iDEBUG_CMD_TARGET,
   input  logic [31:0] iDEBUG_CMD_DATA,
   output logic        oDEBUG_CMD_VALID,
   output logic        oDEBUG_CMD_ERROR,
   output logic [31:0] oDEBUG_CMD_DATA,
   output logic        oCORE_STOP_REQ,
   input  logic        iCORE_STOPPED,
   output logic        oCORE_GO,
   output logic        oCORE_GO_INT,
   output logic        oCORE_STEP,
   input  logic        iCORE_STEP_DONE,
   output logic        oREG_REQ,
   output logic        oREG_RW,
   output logic [7:0]  oREG_TARGET,
   output logic [31:0] oREG_WDATA,
   input  logic        iREG_VALID,
   input  logic [31:0] iREG_RDATA,
   output dbg_state_t  oDEBUG_STATE
);

   // Counter value during the last permitted wait cycle (counter is 0 in the
   // first wait cycle, so P_TIMEOUT wait cycles are allowed in total).
   localparam logic [7:0] LP_LAST_WAIT = 8'(P_TIMEOUT - 1);

   dbg_state_t  r_state;
   dbg_state_t  w_next_state;

   logic [7:0]  r_cnt;
   logic [3:0]  r_cmd;
   logic [7:0]  r_target;
   logic [31:0] r_wdata;
   logic        r_err;
   logic [31:0] r_resp_data;

   logic        w_accept;
   logic        w_tgt_legal;
   logic        w_decode_err;
   logic        w_in_wait;
   logic        w_timeout;
   logic        w_resp_err;
   logic        w_capture;
   logic        w_go;
   logic        w_step;

   core_debug_target_check u_target_check (
      .i_cmd    (r_cmd),
      .i_target (r_target),
      .o_legal  (w_tgt_legal)
   );

   assign w_accept     = (r_state == ST_IDLE) && iDEBUG_CMD_REQ;
   assign w_decode_err = !cmd_is_defined(r_cmd) || !w_tgt_legal ||
                         (cmd_needs_stopped(r_cmd) && !iCORE_STOPPED);
   assign w_in_wait    = (r_state == ST_STOP_WAIT) || (r_state == ST_REG_WAIT) ||
                         (r_state == ST_STEP_WAIT);
   assign w_timeout    = (r_cnt == LP_LAST_WAIT);

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next state and per-cycle strobes
   // ---------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_resp_err   = 1'b0;
      w_capture    = 1'b0;
      w_go         = 1'b0;
      w_step       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (iDEBUG_CMD_REQ) begin
               w_next_state = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (w_decode_err) begin
               w_next_state = ST_RESP;
               w_resp_err   = 1'b1;
            end else begin
               case (r_cmd)
                  CMD_READ_REG, CMD_WRITE_REG: begin
                     w_next_state = ST_REG_WAIT;
                  end
                  CMD_GO, CMD_INTGO: begin
                     w_next_state = ST_RESP;
                     w_go         = 1'b1;
                  end
                  CMD_SINGLESTEP: begin
                     w_next_state = ST_STEP_WAIT;
                     w_step       = 1'b1;
                  end
                  CMD_STOP: begin
                     w_next_state = iCORE_STOPPED ? ST_RESP : ST_STOP_WAIT;
                  end
                  default: begin
                     w_next_state = ST_RESP;
                     w_resp_err   = 1'b1;
                  end
               endcase
            end
         end
         // In every wait state completion is tested before the timeout, so a
         // completion in the last permitted cycle still succeeds.
         ST_STOP_WAIT: begin
            if (iCORE_STOPPED) begin
               w_next_state = ST_RESP;
            end else if (w_timeout) begin
               w_next_state = ST_RESP;
               w_resp_err   = 1'b1;
            end
         end
         ST_REG_WAIT: begin
            if (iREG_VALID) begin
               w_next_state = ST_RESP;
               w_capture    = (r_cmd == CMD_READ_REG);
            end else if (w_timeout) begin
               w_next_state = ST_RESP;
               w_resp_err   = 1'b1;
            end
         end
         ST_STEP_WAIT: begin
            if (iCORE_STEP_DONE) begin
               w_next_state = ST_RESP;
            end else if (w_timeout) begin
               w_next_state = ST_RESP;
               w_resp_err   = 1'b1;
            end
         end
         ST_RESP: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Command latches, response registers and wait counter
   // ---------------------------------------------------------------------
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         r_cnt       <= '0;
         r_cmd       <= '0;
         r_target    <= '0;
         r_wdata     <= '0;
         r_err       <= 1'b0;
         r_resp_data <= '0;
      end else begin
         if (w_accept) begin
            r_cmd       <= iDEBUG_CMD_COMMAND;
            r_target    <= iDEBUG_CMD_TARGET;
            r_wdata     <= iDEBUG_CMD_DATA;
            r_err       <= 1'b0;
            r_resp_data <= '0;
         end
         if (w_resp_err) begin
            r_err <= 1'b1;
         end
         if (w_capture) begin
            r_resp_data <= iREG_RDATA;
         end
         // Outside the wait states the counter sits at zero, so it is already
         // cleared on entry to whichever wait state DECODE selects.
         if (w_in_wait) begin
            r_cnt <= r_cnt + 8'd1;
         end else begin
            r_cnt <= '0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs: decoded from state so reset clears them immediately
   // ---------------------------------------------------------------------
   always_comb begin
      oDEBUG_CMD_BUSY  = (r_state != ST_IDLE);
      oDEBUG_CMD_VALID = (r_state == ST_RESP);
      oDEBUG_CMD_ERROR = (r_state == ST_RESP) && r_err;
      oDEBUG_CMD_DATA  = (r_state == ST_RESP) ? r_resp_data : '0;
      oCORE_STOP_REQ   = (r_state == ST_STOP_WAIT);
      oCORE_GO         = w_go;
      oCORE_GO_INT     = w_go && (r_cmd == CMD_INTGO);
      oCORE_STEP       = w_step;
      oREG_REQ         = (r_state == ST_REG_WAIT);
      oREG_RW          = (r_state == ST_REG_WAIT) && (r_cmd == CMD_WRITE_REG);
      oREG_TARGET      = (r_state == ST_REG_WAIT) ? r_target : '0;
      oREG_WDATA       = (r_state == ST_REG_WAIT) ? r_wdata  : '0;
      oDEBUG_STATE     = r_state;
   end

endmodule

// File: tb/tb_core_debug_responder.sv
module tb_core_debug_responder;
   import core_debug_pkg::*;

   localparam int MAXN = 300;

   // ---------------- clock / reset ----------------
   logic iclk = 1'b0;
   logic rst_n;
   always #5 iclk = ~iclk;

   // ---------------- stimulus (shared by both DUTs) ----------------
   logic        req;
   logic [3:0]  cmd;
   logic [7:0]  tgt;
   logic [31:0] cdata;
   logic        stopped;
   logic        step_done;
   logic        reg_valid;
   logic [31:0] rdata;

   // ---------------- observed outputs: [0] timeout 255, [1] timeout 4 ----------------
   logic [1:0]       busy, valid, err, stop_req, go, go_int, step, reg_req, reg_rw;
   logic [1:0][31:0] rsp_data, reg_wdata;
   logic [1:0][7:0]  reg_tgt;
   logic [1:0][2:0]  dbg_state;

   int tests = 0;
   int fails = 0;

   core_debug_responder u_dut_a (
      .iCLOCK(iclk), .inRESET(rst_n),
      .iDEBUG_CMD_REQ(req), .oDEBUG_CMD_BUSY(busy[0]),
      .iDEBUG_CMD_COMMAND(cmd), .iDEBUG_CMD_TARGET(tgt), .iDEBUG_CMD_DATA(cdata),
      .oDEBUG_CMD_VALID(valid[0]), .oDEBUG_CMD_ERROR(err[0]), .oDEBUG_CMD_DATA(rsp_data[0]),
      .oCORE_STOP_REQ(stop_req[0]), .iCORE_STOPPED(stopped),
      .oCORE_GO(go[0]), .oCORE_GO_INT(go_int[0]),
      .oCORE_STEP(step[0]), .iCORE_STEP_DONE(step_done),
      .oREG_REQ(reg_req[0]), .oREG_RW(reg_rw[0]), .oREG_TARGET(reg_tgt[0]),
      .oREG_WDATA(reg_wdata[0]), .iREG_VALID(reg_valid), .iREG_RDATA(rdata),
      .oDEBUG_STATE(dbg_state[0])
   );

   core_debug_responder #(.P_TIMEOUT(4)) u_dut_b (
      .iCLOCK(iclk), .inRESET(rst_n),
      .iDEBUG_CMD_REQ(req), .oDEBUG_CMD_BUSY(busy[1]),
      .iDEBUG_CMD_COMMAND(cmd), .iDEBUG_CMD_TARGET(tgt), .iDEBUG_CMD_DATA(cdata),
      .oDEBUG_CMD_VALID(valid[1]), .oDEBUG_CMD_ERROR(err[1]), .oDEBUG_CMD_DATA(rsp_data[1]),
      .oCORE_STOP_REQ(stop_req[1]), .iCORE_STOPPED(stopped),
      .oCORE_GO(go[1]), .oCORE_GO_INT(go_int[1]),
      .oCORE_STEP(step[1]), .iCORE_STEP_DONE(step_done),
      .oREG_REQ(reg_req[1]), .oREG_RW(reg_rw[1]), .oREG_TARGET(reg_tgt[1]),
      .oREG_WDATA(reg_wdata[1]), .iREG_VALID(reg_valid), .iREG_RDATA(rdata),
      .oDEBUG_STATE(dbg_state[1])
   );

   // ---------------- reference model ----------------
   typedef struct {
      int          lat;     // negedges after accept until VALID is seen
      logic        err;
      logic [31:0] data;
      int          go;
      int          go_int;
      int          step;
      int          stopreq;
      int          regreq;
   } exp_t;

   // d = wait cycle on which completion arrives (0 = never)
   function automatic exp_t model(input logic [3:0] c, input logic [7:0] t, input logic stp,
                                  input int d, input logic [31:0] rd, input int tmo);
      exp_t e;
      int   w;
      bit   known, is_reg, legal;
      e = '{default: 0};
      e.lat  = 2;
      known  = c inside {4'h0, 4'h1, 4'h8, 4'h9, 4'hA, 4'hF};
      is_reg = c inside {4'h0, 4'h1};
      legal  = (t <= 8'd31) || (t inside {[8'd64:8'd78]}) || (t inside {[8'd128:8'd132]});
      if (!known || (is_reg && (!legal || (c == 4'h1 && t == 8'd64))) ||
          (c != 4'hF && !stp)) begin
         e.err = 1'b1;
         return e;
      end
      if (c == 4'h8 || c == 4'h9) begin
         e.go     = 1;
         e.go_int = (c == 4'h9) ? 1 : 0;
         return e;
      end
      if (c == 4'hF && stp) return e;
      if (d == 0 || d > tmo) begin
         w     = tmo;
         e.err = 1'b1;
      end else begin
         w = d;
      end
      e.lat = 2 + w;
      if (c == 4'hF) e.stopreq = w;
      if (c == 4'hA) e.step = 1;
      if (is_reg) begin
         e.regreq = w;
         if (c == 4'h0 && !e.err) e.data = rd;
      end
      return e;
   endfunction

   // ---------------- scoreboard ----------------
   // Expected response word per DUT: {err, data, latency}
   logic [41:0] exp_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic any_active(input int k);
      return busy[k] | valid[k] | err[k] | (|rsp_data[k]) | stop_req[k] | go[k] |
             go_int[k] | step[k] | reg_req[k] | reg_rw[k] | (|reg_tgt[k]) | (|reg_wdata[k]);
   endfunction

   // ---------------- driver: one command, observed on both DUTs ----------------
   // Called right after a negedge with both DUTs idle.
   task automatic run_cmd(input string tag, input logic [3:0] c, input logic [7:0] t,
                          input logic [31:0] wd, input logic stp, input int d,
                          input logic [31:0] rd);
      exp_t        e[2];
      int          lat_obs[2], vcnt[2], go_cnt[2], goint_cnt[2], step_cnt[2];
      int          stop_cnt[2], regreq_cnt[2], busy_bad[2], idle_bad[2], reg_bad[2];
      logic        err_obs[2];
      logic [31:0] data_obs[2];
      logic [41:0] x;
      int          lat_min, n;
      bit          done;
      string       sfx;
      e[0] = model(c, t, stp, d, rd, 255);
      e[1] = model(c, t, stp, d, rd, 4);
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back({e[k].err, e[k].data, 9'(e[k].lat)});
         lat_obs[k] = 0; vcnt[k] = 0; go_cnt[k] = 0; goint_cnt[k] = 0; step_cnt[k] = 0;
         stop_cnt[k] = 0; regreq_cnt[k] = 0; busy_bad[k] = 0; idle_bad[k] = 0; reg_bad[k] = 0;
         err_obs[k] = 1'b0; data_obs[k] = '0;
      end
      lat_min = (e[0].lat < e[1].lat) ? e[0].lat : e[1].lat;
      req = 1'b1; cmd = c; tgt = t; cdata = wd; stopped = stp; rdata = rd;
      reg_valid = 1'b0; step_done = 1'b0;
      n = 0; done = 0;
      while (!done && n < MAXN) begin
         @(negedge iclk);
         n++;
         for (int k = 0; k < 2; k++) begin
            if (valid[k]) begin
               vcnt[k]++;
               if (lat_obs[k] == 0) begin
                  lat_obs[k] = n; err_obs[k] = err[k]; data_obs[k] = rsp_data[k];
               end
            end else if (err[k] || rsp_data[k] != 32'd0) begin
               idle_bad[k]++;
            end
            if (busy[k] !== ((lat_obs[k] == 0) || (lat_obs[k] == n))) busy_bad[k]++;
            if (go[k]) go_cnt[k]++;
            if (go[k] && go_int[k]) goint_cnt[k]++;
            if (step[k]) step_cnt[k]++;
            if (stop_req[k]) stop_cnt[k]++;
            if (reg_req[k]) begin
               regreq_cnt[k]++;
               if (reg_rw[k] !== (c == 4'h1) || reg_tgt[k] !== t || reg_wdata[k] !== wd)
                  reg_bad[k]++;
            end
         end
         done = (lat_obs[0] != 0) && (lat_obs[1] != 0) && (n > 1 + d);
         // inputs for the next edge: junk REQ/command while busy must be ignored
         req   = (n < lat_min) ? 1'($urandom_range(0, 1)) : 1'b0;
         cmd   = 4'($urandom);
         tgt   = 8'($urandom);
         cdata = $urandom;
         reg_valid = 1'b0;
         step_done = 1'b0;
         if (d > 0 && n == 1 + d) begin
            if (c == 4'hF) stopped = 1'b1;
            else if (c == 4'h0 || c == 4'h1) reg_valid = 1'b1;
            else if (c == 4'hA) step_done = 1'b1;
         end
      end
      req = 1'b0;
      @(negedge iclk);
      chk({tag, "/idle_after"}, {busy, valid}, 4'b0000);
      for (int k = 0; k < 2; k++) begin
         sfx = (k == 0) ? "/A_" : "/B_";
         x = exp_q.pop_front();
         chk({tag, sfx, "lat"},     64'(lat_obs[k]),    64'(x[8:0]));
         chk({tag, sfx, "err"},     64'(err_obs[k]),    64'(x[41]));
         chk({tag, sfx, "data"},    64'(data_obs[k]),   64'(x[40:9]));
         chk({tag, sfx, "vcnt"},    64'(vcnt[k]),       64'd1);
         chk({tag, sfx, "go"},      64'(go_cnt[k]),     64'(e[k].go));
         chk({tag, sfx, "go_int"},  64'(goint_cnt[k]),  64'(e[k].go_int));
         chk({tag, sfx, "step"},    64'(step_cnt[k]),   64'(e[k].step));
         chk({tag, sfx, "stopreq"}, 64'(stop_cnt[k]),   64'(e[k].stopreq));
         chk({tag, sfx, "regreq"},  64'(regreq_cnt[k]), 64'(e[k].regreq));
         chk({tag, sfx, "busy"},    64'(busy_bad[k]),   64'd0);
         chk({tag, sfx, "idle_out"}, 64'(idle_bad[k]),  64'd0);
         chk({tag, sfx, "reg_port"}, 64'(reg_bad[k]),   64'd0);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed + random sequence ----------------
   logic [3:0] cmd_tab [6];
   logic [3:0] rc;
   logic [7:0] rt;
   int         vsum;

   initial begin
      cmd_tab = '{4'h0, 4'h1, 4'h8, 4'h9, 4'hA, 4'hF};
      rst_n = 1'b0; req = 1'b0; cmd = '0; tgt = '0; cdata = '0;
      stopped = 1'b0; step_done = 1'b0; reg_valid = 1'b0; rdata = '0;
      #1;
      chk("reset/A_outputs", 64'(any_active(0)), 64'd0);
      chk("reset/B_outputs", 64'(any_active(1)), 64'd0);
      chk("reset/A_state", 64'(dbg_state[0]), 64'(ST_IDLE));
      chk("reset/B_state", 64'(dbg_state[1]), 64'(ST_IDLE));
      repeat (2) @(negedge iclk);
      rst_n = 1'b1;

      // stopped core, read GR5 answered on the 3rd wait cycle
      run_cmd("read5", 4'h0, 8'd5, 32'h0, 1'b1, 3, 32'h1234_5678);
      // running core, STOP, core halts after 10 request cycles
      run_cmd("stop_run", 4'hF, 8'd0, 32'h0, 1'b0, 10, 32'h0);
      run_cmd("stop_stopped", 4'hF, 8'd0, 32'h0, 1'b1, 2, 32'h0);
      // immediate errors
      run_cmd("wr_cpuidr", 4'h1, 8'd64, 32'hCAFE_0001, 1'b1, 2, 32'h0);
      run_cmd("rd_tgt40", 4'h0, 8'd40, 32'h0, 1'b1, 2, 32'h5555_AAAA);
      run_cmd("rd_run", 4'h0, 8'd3, 32'h0, 1'b0, 2, 32'h0BAD_0BAD);
      run_cmd("undef_cmd", 4'h5, 8'd0, 32'h0, 1'b1, 2, 32'h0);
      // map edges
      run_cmd("rd_tgt132", 4'h0, 8'd132, 32'h0, 1'b1, 1, 32'h0000_0132);
      run_cmd("rd_tgt133", 4'h0, 8'd133, 32'h0, 1'b1, 1, 32'h0000_0133);
      run_cmd("rd_tgt78", 4'h0, 8'd78, 32'h0, 1'b1, 2, 32'h0000_0078);
      run_cmd("rd_tgt79", 4'h0, 8'd79, 32'h0, 1'b1, 2, 32'h0000_0079);
      run_cmd("wr_tgt65", 4'h1, 8'd65, 32'hA5A5_0065, 1'b1, 2, 32'hFFFF_FFFF);
      // single-step: never done, done on 4th wait cycle, done on 5th
      run_cmd("step_none", 4'hA, 8'd0, 32'h0, 1'b1, 0, 32'h0);
      run_cmd("step_d4", 4'hA, 8'd0, 32'h0, 1'b1, 4, 32'h0);
      run_cmd("step_d5", 4'hA, 8'd0, 32'h0, 1'b1, 5, 32'h0);
      run_cmd("rd_d4", 4'h0, 8'd7, 32'h0, 1'b1, 4, 32'h7777_0004);
      // resume
      run_cmd("intgo", 4'h9, 8'd0, 32'h0, 1'b1, 1, 32'h0);
      run_cmd("go_stopped", 4'h8, 8'd0, 32'h0, 1'b1, 1, 32'h0);
      run_cmd("go_run", 4'h8, 8'd0, 32'h0, 1'b0, 1, 32'h0);

      // randomized commands
      for (int i = 0; i < 40; i++) begin
         rc = ($urandom_range(0, 5) == 0) ? 4'($urandom) : cmd_tab[$urandom_range(0, 5)];
         case ($urandom_range(0, 3))
            0:       rt = 8'($urandom_range(0, 31));
            1:       rt = 8'($urandom_range(64, 78));
            2:       rt = 8'($urandom_range(128, 132));
            default: rt = 8'($urandom);
         endcase
         run_cmd($sformatf("rnd%0d", i), rc, rt, $urandom, ($urandom_range(0, 3) != 0),
                 $urandom_range(1, 8), $urandom);
      end

      // reset in the middle of a register access
      req = 1'b1; cmd = 4'h0; tgt = 8'd3; cdata = '0; stopped = 1'b1; rdata = 32'hDEAD_BEEF;
      @(negedge iclk);
      req = 1'b0;
      @(negedge iclk);
      chk("rst_mid/reg_req_before", 64'(reg_req), 64'b11);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid/A_outputs", 64'(any_active(0)), 64'd0);
      chk("rst_mid/B_outputs", 64'(any_active(1)), 64'd0);
      chk("rst_mid/A_state", 64'(dbg_state[0]), 64'(ST_IDLE));
      @(negedge iclk);
      rst_n = 1'b1;
      vsum = 0;
      repeat (6) begin
         @(negedge iclk);
         vsum += int'(valid[0]) + int'(valid[1]) + int'(busy[0]) + int'(busy[1]);
      end
      chk("rst_mid/no_valid_after", 64'(vsum), 64'd0);
      run_cmd("post_rst_read", 4'h0, 8'd3, 32'h0, 1'b1, 2, 32'h0C0F_FEE0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
